// File: rtl/axil_regbank_pkg.sv
// Shared response codes and helpers for the AXI4-Lite register bank.
package axil_regbank_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam int         MAX_DW          = 64;

  // Register-index width once the byte-lane address bits are stripped.
  function automatic int idx_width(input int addr_w, input int data_w);
    return addr_w - $clog2(data_w / 8);
  endfunction

  function automatic logic [MAX_DW-1:0] strb_merge(
    input logic [MAX_DW-1:0]   old_val,
    input logic [MAX_DW-1:0]   new_val,
    input logic [MAX_DW/8-1:0] strb
  );
    logic [MAX_DW-1:0] res;
    res = old_val;
    for (int b = 0; b < MAX_DW / 8; b++) begin
      if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axil_wr_capture.sv
// AW/W holding registers with commit and B-response generation; commit in the cycle both halves are present.
// bvalid one cycle after commit and held until bready; AW/W are refused while a response is pending.
module axil_wr_capture
  import axil_regbank_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 6
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_en,
  input  logic [AW-1:0]   i_awaddr,
  input  logic            i_awvalid,
  output logic            o_awready,
  input  logic [DW-1:0]   i_wdata,
  input  logic [DW/8-1:0] i_wstrb,
  input  logic            i_wvalid,
  output logic            o_wready,
  output logic [1:0]      o_bresp,
  output logic            o_bvalid,
  input  logic            i_bready,
  output logic            o_commit,
  output logic [AW-1:0]   o_cmt_addr,
  output logic [DW-1:0]   o_cmt_data,
  output logic [DW/8-1:0] o_cmt_strb,
  input  logic            i_cmt_legal
);

  logic            r_aw_held;
  logic            r_w_held;
  logic [AW-1:0]   r_awaddr;
  logic [DW-1:0]   r_wdata;
  logic [DW/8-1:0] r_wstrb;
  logic            r_bvalid;
  logic [1:0]      r_bresp;

  logic w_aw_hs;
  logic w_w_hs;

  assign o_awready = i_en && !r_aw_held && !r_bvalid;
  assign o_wready  = i_en && !r_w_held && !r_bvalid;
  assign w_aw_hs   = i_awvalid && o_awready;
  assign w_w_hs    = i_wvalid && o_wready;

  // A half arriving in the same cycle as its partner is forwarded straight to commit.
  assign o_commit   = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs) && !r_bvalid;
  assign o_cmt_addr = r_aw_held ? r_awaddr : i_awaddr;
  assign o_cmt_data = r_w_held ? r_wdata : i_wdata;
  assign o_cmt_strb = r_w_held ? r_wstrb : i_wstrb;

  assign o_bvalid = r_bvalid;
  assign o_bresp  = r_bresp;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= AXI_RESP_OKAY;
    end else begin
      if (w_aw_hs) r_awaddr <= i_awaddr;
      if (w_w_hs) begin
        r_wdata <= i_wdata;
        r_wstrb <= i_wstrb;
      end
      if (o_commit) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= i_cmt_legal ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
      end else begin
        if (w_aw_hs) r_aw_held <= 1'b1;
        if (w_w_hs) r_w_held <= 1'b1;
        if (r_bvalid && i_bready) r_bvalid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/axil_regbank_gen2.sv
// AXI4-Lite register bank with fabric status registers, self-clearing commands and per-register access pulses.
// Read latency 1 cycle; one write and one read in flight, responses held until bready/rready.
module axil_regbank_gen2
  import axil_regbank_pkg::*;
#(
  parameter int                  C_S_AXI_DATA_WIDTH = 32,
  parameter int                  C_S_AXI_ADDR_WIDTH = 6,
  parameter int                  NUM_REGS           = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK            = '0,
  parameter logic [NUM_REGS-1:0] SC_MASK            = '0
) (
  input  logic                                   s00_axi_aclk,
  input  logic                                   s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          s00_axi_awaddr,
  input  logic [2:0]                             s00_axi_awprot,
  input  logic                                   s00_axi_awvalid,
  output logic                                   s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        s00_axi_wstrb,
  input  logic                                   s00_axi_wvalid,
  output logic                                   s00_axi_wready,
  output logic [1:0]                             s00_axi_bresp,
  output logic                                   s00_axi_bvalid,
  input  logic                                   s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          s00_axi_araddr,
  input  logic [2:0]                             s00_axi_arprot,
  input  logic                                   s00_axi_arvalid,
  output logic                                   s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]          s00_axi_rdata,
  output logic [1:0]                             s00_axi_rresp,
  output logic                                   s00_axi_rvalid,
  input  logic                                   s00_axi_rready,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
  input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_in,
  output logic [NUM_REGS-1:0]                    wr_pulse,
  output logic [NUM_REGS-1:0]                    rd_pulse
);

  localparam int DW   = C_S_AXI_DATA_WIDTH;
  localparam int AW   = C_S_AXI_ADDR_WIDTH;
  localparam int LSB  = $clog2(DW / 8);
  localparam int IDXW = idx_width(AW, DW);
  localparam int NIDX = 1 << IDXW;

  logic [DW-1:0]       r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_wr_pulse;
  logic                r_init;
  logic                r_rvalid;
  logic [DW-1:0]       r_rdata;
  logic [1:0]          r_rresp;

  logic                w_commit;
  logic                w_wr_legal;
  logic [AW-1:0]       w_cmt_addr;
  logic [DW-1:0]       w_cmt_data;
  logic [DW/8-1:0]     w_cmt_strb;
  logic [IDXW-1:0]     w_wr_idx;
  logic [IDXW-1:0]     w_rd_idx;
  logic [NIDX-1:0]     w_exist;
  logic [NIDX-1:0]     w_ro;
  logic [NUM_REGS-1:0] w_wr_hit;
  logic [DW-1:0]       w_old;
  logic [DW-1:0]       w_merged;
  logic [DW-1:0]       w_rd_val;
  logic                w_ar_hs;
  logic                w_unused_ok;

  // Holds all readies low until the first clock after reset release.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) r_init <= 1'b0;
    else                  r_init <= 1'b1;
  end

  axil_wr_capture #(
    .DW (DW),
    .AW (AW)
  ) u_wr_capture (
    .i_clk       (s00_axi_aclk),
    .i_rst_n     (s00_axi_aresetn),
    .i_en        (r_init),
    .i_awaddr    (s00_axi_awaddr),
    .i_awvalid   (s00_axi_awvalid),
    .o_awready   (s00_axi_awready),
    .i_wdata     (s00_axi_wdata),
    .i_wstrb     (s00_axi_wstrb),
    .i_wvalid    (s00_axi_wvalid),
    .o_wready    (s00_axi_wready),
    .o_bresp     (s00_axi_bresp),
    .o_bvalid    (s00_axi_bvalid),
    .i_bready    (s00_axi_bready),
    .o_commit    (w_commit),
    .o_cmt_addr  (w_cmt_addr),
    .o_cmt_data  (w_cmt_data),
    .o_cmt_strb  (w_cmt_strb),
    .i_cmt_legal (w_wr_legal)
  );

  // Masks widened to the full index space so out-of-range indices decode as absent.
  always_comb begin
    w_exist = '0;
    w_ro    = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_exist[i] = 1'b1;
      w_ro[i]    = RO_MASK[i];
    end
  end

  assign w_wr_idx   = w_cmt_addr[AW-1:LSB];
  assign w_rd_idx   = s00_axi_araddr[AW-1:LSB];
  assign w_wr_legal = w_exist[w_wr_idx] && !w_ro[w_wr_idx];

  always_comb begin
    w_wr_hit = '0;
    w_old    = '0;
    w_rd_val = '0;
    rd_pulse = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_wr_idx == IDXW'(i)) begin
        w_old       = r_regs[i];
        w_wr_hit[i] = w_commit && w_wr_legal;
      end
      if (w_rd_idx == IDXW'(i)) begin
        w_rd_val    = RO_MASK[i] ? reg_in[i*DW +: DW] : r_regs[i];
        rd_pulse[i] = w_ar_hs;
      end
    end
  end

  assign w_merged = DW'(strb_merge(64'(w_old), 64'(w_cmt_data), 8'(w_cmt_strb)));

  // A fresh write to a command register wins over its pending self-clear.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      r_wr_pulse <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_wr_hit[i])                       r_regs[i] <= w_merged;
        else if (SC_MASK[i] && r_wr_pulse[i])  r_regs[i] <= '0;
      end
      r_wr_pulse <= w_wr_hit;
    end
  end

  assign wr_pulse = r_wr_pulse;

  always_comb begin
    reg_out = '0;
    for (int i = 0; i < NUM_REGS; i++) reg_out[i*DW +: DW] = r_regs[i];
  end

  assign s00_axi_arready = r_init && !r_rvalid;
  assign w_ar_hs         = s00_axi_arvalid && s00_axi_arready;

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= AXI_RESP_OKAY;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rd_val;
      r_rresp  <= w_exist[w_rd_idx] ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
    end else if (s00_axi_rready) begin
      r_rvalid <= 1'b0;
    end
  end

  assign s00_axi_rvalid = r_rvalid;
  assign s00_axi_rdata  = r_rdata;
  assign s00_axi_rresp  = r_rresp;

  assign w_unused_ok = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_araddr[LSB-1:0], w_cmt_addr[LSB-1:0]};

endmodule

// File: tb/tb_axil_regbank_gen2.sv
// Bench for axil_regbank_gen2: plain 16-register bank (A) and an 8-register bank with RO reg 2 and
// self-clearing reg 5 (B) share one stimulus bus; responses are checked against a scoreboard.
module tb_axil_regbank_gen2;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef struct {
    bit         sel;
    logic [1:0] resp;
    logic [31:0] data;
  } exp_t;

  exp_t exp_b_q[$];
  exp_t exp_r_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [5:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;

  logic         a_awready, a_wready, a_bvalid, a_arready, a_rvalid;
  logic [1:0]   a_bresp, a_rresp;
  logic [31:0]  a_rdata;
  logic [511:0] a_reg_out, a_reg_in;
  logic [15:0]  a_wr_pulse, a_rd_pulse;

  logic         b_awready, b_wready, b_bvalid, b_arready, b_rvalid;
  logic [1:0]   b_bresp, b_rresp;
  logic [31:0]  b_rdata;
  logic [255:0] b_reg_out, b_reg_in;
  logic [7:0]   b_wr_pulse, b_rd_pulse;

  axil_regbank_gen2 dut_a (
    .s00_axi_aclk (clk), .s00_axi_aresetn (rst_n),
    .s00_axi_awaddr (awaddr), .s00_axi_awprot (awprot), .s00_axi_awvalid (awvalid), .s00_axi_awready (a_awready),
    .s00_axi_wdata (wdata), .s00_axi_wstrb (wstrb), .s00_axi_wvalid (wvalid), .s00_axi_wready (a_wready),
    .s00_axi_bresp (a_bresp), .s00_axi_bvalid (a_bvalid), .s00_axi_bready (bready),
    .s00_axi_araddr (araddr), .s00_axi_arprot (arprot), .s00_axi_arvalid (arvalid), .s00_axi_arready (a_arready),
    .s00_axi_rdata (a_rdata), .s00_axi_rresp (a_rresp), .s00_axi_rvalid (a_rvalid), .s00_axi_rready (rready),
    .reg_out (a_reg_out), .reg_in (a_reg_in), .wr_pulse (a_wr_pulse), .rd_pulse (a_rd_pulse)
  );

  axil_regbank_gen2 #(
    .NUM_REGS (8), .RO_MASK (8'h04), .SC_MASK (8'h20)
  ) dut_b (
    .s00_axi_aclk (clk), .s00_axi_aresetn (rst_n),
    .s00_axi_awaddr (awaddr), .s00_axi_awprot (awprot), .s00_axi_awvalid (awvalid), .s00_axi_awready (b_awready),
    .s00_axi_wdata (wdata), .s00_axi_wstrb (wstrb), .s00_axi_wvalid (wvalid), .s00_axi_wready (b_wready),
    .s00_axi_bresp (b_bresp), .s00_axi_bvalid (b_bvalid), .s00_axi_bready (bready),
    .s00_axi_araddr (araddr), .s00_axi_arprot (arprot), .s00_axi_arvalid (arvalid), .s00_axi_arready (b_arready),
    .s00_axi_rdata (b_rdata), .s00_axi_rresp (b_rresp), .s00_axi_rvalid (b_rvalid), .s00_axi_rready (rready),
    .reg_out (b_reg_out), .reg_in (b_reg_in), .wr_pulse (b_wr_pulse), .rd_pulse (b_rd_pulse)
  );

  // Drives one write; w_lead > 0 issues W that many cycles ahead of AW. Returns just after the commit edge.
  task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int w_lead, input bit sel, input logic [1:0] exp_resp);
    exp_t e;
    int   n;
    e.sel = sel; e.resp = exp_resp; e.data = '0;
    exp_b_q.push_back(e);
    awaddr = a; wdata = d; wstrb = s;
    if (w_lead > 0) begin
      wvalid = 1'b1;
      n = 0;
      while (!a_wready && n < 20) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      wvalid = 1'b0;
      repeat (w_lead - 1) @(posedge clk);
      #1;
    end else begin
      wvalid = 1'b1;
    end
    awvalid = 1'b1;
    n = 0;
    while (!(a_awready && (a_wready || !wvalid)) && n < 20) begin @(posedge clk); #1; n++; end
    if (n >= 20) begin
      n_tests++; n_fail++;
      $display("FAIL write_ready_timeout addr=%h awready=%b wready=%b", a, a_awready, a_wready);
    end
    @(posedge clk); #1;
    awvalid = 1'b0;
    wvalid  = 1'b0;
  endtask

  task automatic collect_b();
    exp_t e;
    int   n;
    n_tests++;
    if (exp_b_q.size() == 0) begin
      n_fail++;
      $display("FAIL b_scoreboard_empty");
      return;
    end
    e = exp_b_q.pop_front();
    n = 0;
    while (!(e.sel ? b_bvalid : a_bvalid) && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) begin
      n_fail++;
      $display("FAIL bvalid_timeout dut=%0d", e.sel);
      return;
    end
    if ((e.sel ? b_bresp : a_bresp) !== e.resp) begin
      n_fail++;
      $display("FAIL bresp dut=%0d got=%b expected=%b", e.sel, e.sel ? b_bresp : a_bresp, e.resp);
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  // pulse_idx < 0 means no rd_pulse bit may fire during the handshake.
  task automatic axi_read(input logic [5:0] a, input logic [31:0] exp_data, input logic [1:0] exp_resp,
                          input bit sel, input int pulse_idx);
    exp_t        e;
    int          n;
    logic [15:0] got_p, exp_p;
    e.sel = sel; e.resp = exp_resp; e.data = exp_data;
    exp_r_q.push_back(e);
    araddr  = a;
    arvalid = 1'b1;
    #1;
    n = 0;
    while (!a_arready && n < 20) begin @(posedge clk); #2; n++; end
    got_p = sel ? 16'(b_rd_pulse) : a_rd_pulse;
    exp_p = (pulse_idx < 0) ? 16'h0 : (16'h1 << pulse_idx);
    n_tests++;
    if (got_p !== exp_p) begin
      n_fail++;
      $display("FAIL rd_pulse addr=%h dut=%0d got=%h expected=%h", a, sel, got_p, exp_p);
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic collect_r();
    exp_t        e;
    int          n;
    logic [31:0] gd;
    logic [1:0]  gr;
    n_tests++;
    if (exp_r_q.size() == 0) begin
      n_fail++;
      $display("FAIL r_scoreboard_empty");
      return;
    end
    e = exp_r_q.pop_front();
    n = 0;
    while (!(e.sel ? b_rvalid : a_rvalid) && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) begin
      n_fail++;
      $display("FAIL rvalid_timeout dut=%0d", e.sel);
      return;
    end
    gd = e.sel ? b_rdata : a_rdata;
    gr = e.sel ? b_rresp : a_rresp;
    if ({gr, gd} !== {e.resp, e.data}) begin
      n_fail++;
      $display("FAIL rdata dut=%0d got=%h/%b expected=%h/%b", e.sel, gd, gr, e.data, e.resp);
    end
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({a_awready, a_wready, a_arready, a_bvalid, a_rvalid} !== 5'b0) begin
      n_fail++;
      $display("FAIL in_reset_handshake got=%b expected=00000",
               {a_awready, a_wready, a_arready, a_bvalid, a_rvalid});
    end
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({a_awready, a_wready, a_arready, a_bvalid, a_rvalid, b_awready, b_wready, b_arready} !== 8'b11100111) begin
      n_fail++;
      $display("FAIL post_reset_handshake got=%b expected=11100111",
               {a_awready, a_wready, a_arready, a_bvalid, a_rvalid, b_awready, b_wready, b_arready});
    end
    n_tests++;
    if ({a_bresp, a_rresp, a_rdata} !== 36'h0) begin
      n_fail++;
      $display("FAIL post_reset_resp got=%h expected=0", {a_bresp, a_rresp, a_rdata});
    end
    n_tests++;
    if (a_reg_out !== '0 || b_reg_out !== '0 || a_wr_pulse !== '0 || a_rd_pulse !== '0) begin
      n_fail++;
      $display("FAIL post_reset_regs got=%h/%h expected=0", a_reg_out[127:0], a_wr_pulse);
    end
  endtask

  task automatic test_regression();
    for (int i = 0; i < 4; i++) begin
      axi_write(6'(i * 4), 32'(i + 1), 4'hF, 0, 1'b0, OKAY);
      collect_b();
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(6'(i * 4), 32'(i + 1), OKAY, 1'b0, i);
      collect_r();
    end
  endtask

  task automatic test_strobe_order();
    axi_write(6'h10, 32'hAABBCCDD, 4'b0101, 3, 1'b0, OKAY);
    n_tests++;
    if (a_reg_out[4*32 +: 32] !== 32'h00BB00DD) begin
      n_fail++;
      $display("FAIL strobe_merge got=%h expected=00bb00dd", a_reg_out[4*32 +: 32]);
    end
    n_tests++;
    if (a_wr_pulse !== 16'h0010) begin
      n_fail++;
      $display("FAIL wr_pulse_on got=%h expected=0010", a_wr_pulse);
    end
    @(posedge clk); #1;
    n_tests++;
    if (a_wr_pulse !== 16'h0000) begin
      n_fail++;
      $display("FAIL wr_pulse_off got=%h expected=0000", a_wr_pulse);
    end
    collect_b();
  endtask

  task automatic test_illegal();
    axi_write(6'h08, 32'h1234, 4'hF, 0, 1'b1, SLVERR);
    n_tests++;
    if (b_reg_out[2*32 +: 32] !== 32'h0 || b_wr_pulse !== 8'h00) begin
      n_fail++;
      $display("FAIL ro_write_effect got=%h pulse=%h expected=0/00", b_reg_out[2*32 +: 32], b_wr_pulse);
    end
    collect_b();
    b_reg_in[2*32 +: 32] = 32'hCAFE0001;
    axi_read(6'h08, 32'hCAFE0001, OKAY, 1'b1, 2);
    collect_r();
    axi_read(6'h3C, 32'h0, SLVERR, 1'b1, -1);
    collect_r();
  endtask

  task automatic test_self_clear();
    axi_write(6'h14, 32'h1, 4'hF, 0, 1'b1, OKAY);
    n_tests++;
    if (b_reg_out[5*32 +: 32] !== 32'h1 || b_wr_pulse !== 8'h20) begin
      n_fail++;
      $display("FAIL sc_first_cycle got=%h pulse=%h expected=1/20", b_reg_out[5*32 +: 32], b_wr_pulse);
    end
    @(posedge clk); #1;
    n_tests++;
    if (b_reg_out[5*32 +: 32] !== 32'h0) begin
      n_fail++;
      $display("FAIL sc_cleared got=%h expected=0", b_reg_out[5*32 +: 32]);
    end
    collect_b();
    axi_read(6'h14, 32'h0, OKAY, 1'b1, 5);
    collect_r();
  endtask

  task automatic test_backpressure();
    axi_write(6'h18, 32'h55, 4'hF, 0, 1'b0, OKAY);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if ({a_bvalid, a_awready, a_wready} !== 3'b100) begin
        n_fail++;
        $display("FAIL b_hold cyc=%0d got=%b expected=100", i, {a_bvalid, a_awready, a_wready});
      end
    end
    collect_b();
    axi_read(6'h04, 32'd2, OKAY, 1'b0, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if ({a_rvalid, a_arready, a_rdata} !== {2'b10, 32'd2}) begin
        n_fail++;
        $display("FAIL r_hold cyc=%0d got=%b%b/%h expected=10/00000002", i, a_rvalid, a_arready, a_rdata);
      end
    end
    collect_r();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    e.sel = 1'b0; e.resp = OKAY; e.data = '0;
    exp_b_q.push_back(e);
    e.data = 32'd4;
    exp_r_q.push_back(e);
    awaddr = 6'h0C; wdata = 32'h77; wstrb = 4'hF; araddr = 6'h0C;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    collect_b();
    collect_r();
    axi_read(6'h0C, 32'h77, OKAY, 1'b0, 3);
    collect_r();
  endtask

  task automatic test_reset_mid();
    axi_write(6'h1C, 32'h99, 4'hF, 0, 1'b0, OKAY);
    axi_read(6'h00, 32'd1, OKAY, 1'b0, 0);
    n_tests++;
    if ({a_bvalid, a_rvalid} !== 2'b11) begin
      n_fail++;
      $display("FAIL pre_abort_valid got=%b expected=11", {a_bvalid, a_rvalid});
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({a_bvalid, a_rvalid, b_bvalid, b_rvalid} !== 4'b0000) begin
      n_fail++;
      $display("FAIL abort_valid got=%b expected=0000", {a_bvalid, a_rvalid, b_bvalid, b_rvalid});
    end
    exp_b_q.delete();
    exp_r_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (a_reg_out !== '0 || {a_awready, a_wready, a_arready, a_bvalid, a_rvalid} !== 5'b11100) begin
      n_fail++;
      $display("FAIL post_abort_state regs=%h hs=%b expected=0/11100", a_reg_out[127:0],
               {a_awready, a_wready, a_arready, a_bvalid, a_rvalid});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    awaddr  = '0; araddr = '0; awprot = '0; arprot = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    wdata   = '0; wstrb = '0;
    a_reg_in = '0;
    b_reg_in = '0;

    test_reset();
    test_regression();
    test_strobe_order();
    test_illegal();
    test_self_clear();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();

    n_tests++;
    if (exp_b_q.size() != 0 || exp_r_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover b=%0d r=%0d expected=0/0", exp_b_q.size(), exp_r_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axil_regbank_gen2.md
Name: axil_regbank_gen2

Overview:
Parametrised AXI4-Lite slave register bank, the successor to the fixed 4-register simu_rec slave. It is used as the control/status interface between the PS AXI master and memristor test logic in the CLS_frontend AXI IPs. New capabilities:
- Configurable register count.
- Byte strobes.
- Independent AW/W acceptance.
- Read-only status registers driven from fabric.
- Self-clearing command bits.
- Per-register access pulses.
- SLVERR on illegal accesses.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width; legal values are 32 and 64.
C_S_AXI_ADDR_WIDTH, 6, byte address width; must satisfy 2^ADDR_W >= NUM_REGS*(DW/8).
NUM_REGS, 16, number of word registers (1..64).
RO_MASK, 16'h0000, bit i=1 means register i is read-only and reads reg_in slice i.
SC_MASK, 16'h0000, bit i=1 means register i self-clears one cycle after a write (command register).

Ports:
s00_axi_aclk  in  1  clock
s00_axi_aresetn  in  1  asynchronous active-low reset
s00_axi_awaddr  in  ADDR_W  write address
s00_axi_awprot  in  3  ignored
s00_axi_awvalid / s00_axi_awready  in / out  1  AW handshake
s00_axi_wdata  in  DW  write data
s00_axi_wstrb  in  DW/8  byte enables
s00_axi_wvalid / s00_axi_wready  in / out  1  W handshake
s00_axi_bresp  out  2  write response
s00_axi_bvalid / s00_axi_bready  out / in  1  B handshake
s00_axi_araddr  in  ADDR_W  read address
s00_axi_arprot  in  3  ignored
s00_axi_arvalid / s00_axi_arready  in / out  1  AR handshake
s00_axi_rdata  out  DW  read data
s00_axi_rresp  out  2  read response
s00_axi_rvalid / s00_axi_rready  out / in  1  R handshake
reg_out  out  NUM_REGS*DW  current RW register contents; slice i is register i
reg_in  in  NUM_REGS*DW  status inputs, used only for RO registers
wr_pulse  out  NUM_REGS  one-cycle strobe when register i is written successfully
rd_pulse  out  NUM_REGS  one-cycle strobe when register i read data is launched

Behaviour:
- Reset (async assert, sync release): all ready/valid outputs 0, bresp/rresp 2'b00, rdata 0, all registers 0, pulses 0.
- Reset asserted mid-transaction aborts the transaction silently; no response is issued.
- Address decode: idx = addr[ADDR_W-1:log2(DW/8)]; low address bits are ignored.
- AW channel: awready = !aw_held && !bvalid. On handshake, the address is latched and aw_held is set.
- W channel: wready = !w_held && !bvalid. On handshake, data and strobe are latched and w_held is set.
- AW and W may arrive in either order or in the same cycle.
- Write commit occurs in the cycle where aw_held && w_held (or the handshakes complete) and bvalid=0.
  - Legal write (idx < NUM_REGS and RO_MASK[idx]=0): bytes with strobe=1 are updated; bresp=OKAY; wr_pulse[idx]=1 next cycle.
  - Illegal write (idx >= NUM_REGS, or RO_MASK[idx]=1): no register change; bresp=SLVERR (2'b10); no pulse.
  - bvalid rises the cycle after commit. aw_held and w_held are cleared at commit.
- B channel: bvalid holds until bready. No new AW/W is accepted while bvalid=1, so at most one write is outstanding.
- Self-clear: if SC_MASK[idx]=1, the register holds the written value for exactly one cycle, then returns to 0. A new write in that cycle takes priority over the clear.
- Read: arready = !rvalid. On AR handshake, rdata/rresp are registered and rvalid=1 the next cycle (latency 1). Values held until rready.
  - idx >= NUM_REGS: rdata=0, rresp=SLVERR.
  - RO register: rdata = reg_in slice sampled at the handshake cycle.
  - Otherwise: rdata = stored value.
  - rd_pulse[idx]=1 in the same cycle as the AR handshake, legal addresses only.
- Simultaneous read and write commit to the same register: the read returns the pre-write value.
- Read and write paths are fully independent; back-to-back reads give 1 transfer per 2 cycles.

Decomposition:
- Package axil_regbank_pkg:
  - AXI_RESP_OKAY = 2'b00, AXI_RESP_SLVERR = 2'b10.
  - Function for byte-strobe merge.
  - Function for index decode width (clog2).
- One sub-module, axil_wr_capture: AW/W holding registers plus commit/B-response logic. Read path and register array stay in the top module.

Test Plan:
- Reset state: after reset release, no stimulus -> all readies 0 except awready/wready/arready = 1; reg_out all 0.
- Sequential regression: write 1, 2, 3, 4 to 0x00, 0x04, 0x08, 0x0C, then read back -> rdata 1, 2, 3, 4, all OKAY.
- Strobe and ordering: W (0xAABBCCDD, wstrb=4'b0101) issued 3 cycles before AW 0x10 -> reg4 = 0x00BB00DD; bresp OKAY; wr_pulse[4] high 1 cycle.
- Illegal accesses with RO_MASK[2]=1:
  - Write 0x1234 to 0x08 -> SLVERR; reg unchanged.
  - With reg_in slice 2 = 0xCAFE0001, read 0x08 -> 0xCAFE0001, OKAY.
  - Read 0x3C with NUM_REGS=8 -> rdata 0, SLVERR.
- Self-clear with SC_MASK[5]=1: write 0x1 to 0x14 -> reg_out slice 5 high exactly 1 cycle; later read returns 0.
- Backpressure and reset:
  - Hold bready=0 for 10 cycles -> bvalid stays 1, awready/wready stay 0.
  - Hold rready=0 -> rdata stable.
  - Assert aresetn low mid-response -> bvalid/rvalid drop to 0 immediately.
